// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: frame controller for an asynchronous serial receiver.
// Synchronizes the raw line and detects the start edge. It also runs an
// external bit timer, collects start + 8 data + stop into a shift register,
// checks the stop bit and hands the byte to a consumer.
//
// Consumer handshake: data_ready is the valid flag for rx_data. A byte
// counts as consumed on any rising edge where data_ready = 1 and
// data_read = 1. data_read while data_ready = 0 is ignored. A new byte
// loaded while the old one is still unread overwrites rx_data and raises
// overrun_error, unless data_read consumes the old byte in that same cycle.
module rx_frame_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic       shift_strobe,
  input  logic       packet_done,
  input  logic       data_read,
  output logic       enable_timer,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RECEIVE = 3'd2,
    S_CHECK   = 3'd3,
    S_LOAD    = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_fill;
  logic [8:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_data_ready;
  logic       r_framing_error;
  logic       r_overrun_error;

  logic       w_line_valid;
  logic       w_start_edge;
  logic       w_enable_timer;
  logic       w_clear_fe;
  logic       w_stop_bad;
  logic       w_load;

  // Two-flop synchronizer plus a previous-value flop for edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Count the cycles after reset until r_prev holds a sample taken from the
  // real line. Until then, the 1s forced into the pipeline by reset could
  // look like a falling edge when the line is already low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_fill <= 2'd0;
    end else if (r_fill != 2'd3) begin
      r_fill <= r_fill + 2'd1;
    end
  end

  assign w_line_valid = (r_fill == 2'd3);
  assign w_start_edge = w_line_valid && r_prev && !r_sync2;

  // Shift register: LSB-first frame enters at bit 8 on every timer strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift <= 9'h1FF;
    end else if (shift_strobe) begin
      r_shift <= {r_sync2, r_shift[8:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_start_edge) w_next_state = S_START;
      S_START:   w_next_state = S_RECEIVE;
      S_RECEIVE: if (packet_done) w_next_state = S_CHECK;
      S_CHECK:   w_next_state = r_shift[8] ? S_LOAD : S_IDLE;
      S_LOAD:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: timer enable and the per-state datapath controls.
  always_comb begin
    w_enable_timer = 1'b0;
    w_clear_fe     = 1'b0;
    w_stop_bad     = 1'b0;
    w_load         = 1'b0;
    case (r_state)
      S_START:   w_clear_fe     = 1'b1;
      S_RECEIVE: w_enable_timer = 1'b1;
      S_CHECK:   w_stop_bad     = !r_shift[8];
      S_LOAD:    w_load         = 1'b1;
      default:   ;
    endcase
  end

  // Framing error: cleared when a new frame starts, set on a bad stop bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_framing_error <= 1'b0;
    end else if (w_clear_fe) begin
      r_framing_error <= 1'b0;
    end else if (w_stop_bad) begin
      r_framing_error <= 1'b1;
    end
  end

  // Output byte, ready flag and overrun flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data       <= 8'h00;
      r_data_ready    <= 1'b0;
      r_overrun_error <= 1'b0;
    end else if (w_load) begin
      r_rx_data       <= r_shift[7:0];
      r_data_ready    <= 1'b1;
      r_overrun_error <= r_data_ready && !data_read;
    end else if (data_read && r_data_ready) begin
      r_data_ready    <= 1'b0;
      r_overrun_error <= 1'b0;
    end
  end

  assign enable_timer  = w_enable_timer;
  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign framing_error = r_framing_error;
  assign overrun_error = r_overrun_error;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge. The bench models the bit timer:
// one bit every 10 clocks, a strobe in mid-bit, then packet_done.
module tb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       shift_strobe = 1'b0;
  logic       packet_done = 1'b0;
  logic       data_read = 1'b0;
  logic       enable_timer;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECEIVE = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_LOAD    = 3'd4;

  rx_frame_ctrl dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .shift_strobe  (shift_strobe),
    .packet_done   (packet_done),
    .data_read     (data_read),
    .enable_timer  (enable_timer),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .dbg_state     (dbg_state)
  );

  // Clock and reset block: 10-unit clock period.
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: send the first nbits bits of {stop, data, start} with one
  // strobe in the middle of each 10-clock bit.
  task automatic send_bits(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      serial_in = bits[k];
      for (int c = 0; c < 10; c++) begin
        shift_strobe = (c == 5);
        if (k == 0 && c == 5) begin
          check("timer_on", {31'd0, enable_timer}, 32'd1);
          check("state_receive", {29'd0, dbg_state}, {29'd0, ST_RECEIVE});
          check("fe_cleared_in_start", {31'd0, framing_error}, 32'd0);
        end
        tick();
      end
    end
    shift_strobe = 1'b0;
  endtask

  // Driver: a full frame followed by packet_done, optionally with data_read
  // in the LOAD cycle. exp_dr_prev is data_ready before the load.
  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic rd_in_load,
                          input logic exp_dr_prev);
    send_bits(d, stop, 10);
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    check("state_check", {29'd0, dbg_state}, {29'd0, ST_CHECK});
    check("dr_before_load", {31'd0, data_ready}, {31'd0, exp_dr_prev});
    tick();
    if (stop) begin
      exp_q.push_back(d);
      check("state_load", {29'd0, dbg_state}, {29'd0, ST_LOAD});
      check("dr_latency", {31'd0, data_ready}, {31'd0, exp_dr_prev});
      if (rd_in_load) data_read = 1'b1;
      tick();
      data_read = 1'b0;
      check("state_idle_after_load", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    end else begin
      check("state_idle_after_bad", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      check("fe_set", {31'd0, framing_error}, 32'd1);
    end
  endtask

  // Scoreboard: compare rx_data with the oldest expected byte.
  task automatic check_rx(input string tag);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    check(tag, {24'd0, rx_data}, {24'd0, exp});
  endtask

  task automatic check_flags(input string tag, input logic dr, input logic fe, input logic ov);
    check({tag, "_dr"}, {31'd0, data_ready}, {31'd0, dr});
    check({tag, "_fe"}, {31'd0, framing_error}, {31'd0, fe});
    check({tag, "_ov"}, {31'd0, overrun_error}, {31'd0, ov});
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  initial begin
    // Reset values are held asynchronously.
    #2 n_rst = 1'b0;
    #1;
    check("rst_timer", {31'd0, enable_timer}, 32'd0);
    check("rst_rx", {24'd0, rx_data}, 32'h00);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    tick(2);
    n_rst = 1'b1;
    tick(3);
    check("idle_after_rst", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Good frame A5.
    rx_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_rx("rx_a5");
    check_flags("a5", 1'b1, 1'b0, 1'b0);
    tick(5);

    // Bad stop bit: byte 3C is dropped, A5 stays pending.
    rx_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("rx_kept_a5", {24'd0, rx_data}, 32'hA5);
    check_flags("fe", 1'b1, 1'b1, 1'b0);
    // A line that is still low on return to IDLE is not a start.
    tick(10);
    check("idle_line_low", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("timer_off_low", {31'd0, enable_timer}, 32'd0);
    serial_in = 1'b1;
    tick(5);

    // Consume A5. A second read while empty has no effect.
    pulse_read();
    check_flags("read_a5", 1'b0, 1'b1, 1'b0);
    pulse_read();
    check_flags("read_empty", 1'b0, 1'b1, 1'b0);
    check("rx_after_reads", {24'd0, rx_data}, 32'hA5);

    // Overrun: 11 then 22 with no read. The start of 11 clears framing_error.
    rx_frame(8'h11, 1'b1, 1'b0, 1'b0);
    check_rx("rx_11");
    check_flags("b11", 1'b1, 1'b0, 1'b0);
    tick(5);
    rx_frame(8'h22, 1'b1, 1'b0, 1'b1);
    check_rx("rx_22");
    check_flags("overrun", 1'b1, 1'b0, 1'b1);
    pulse_read();
    check_flags("read_ovr", 1'b0, 1'b0, 1'b0);
    tick(5);

    // A read in the LOAD cycle consumes the old byte, with no overrun.
    rx_frame(8'h44, 1'b1, 1'b0, 1'b0);
    check_rx("rx_44");
    tick(5);
    rx_frame(8'h55, 1'b1, 1'b1, 1'b1);
    check_rx("rx_55");
    check_flags("read_in_load", 1'b1, 1'b0, 1'b0);
    tick(5);

    // Reset during RECEIVE after 4 strobes aborts the frame.
    send_bits(8'h9A, 1'b1, 4);
    check("timer_mid_frame", {31'd0, enable_timer}, 32'd1);
    n_rst = 1'b0;
    serial_in = 1'b1;
    #1;
    check("abort_timer", {31'd0, enable_timer}, 32'd0);
    check("abort_rx", {24'd0, rx_data}, 32'h00);
    check_flags("abort", 1'b0, 1'b0, 1'b0);
    check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    tick(2);
    n_rst = 1'b1;
    tick();
    check("idle_after_abort", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    tick(2);
    rx_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    check_rx("rx_f0");
    check_flags("f0", 1'b1, 1'b0, 1'b0);
    tick(5);

    // Line held low through reset release: no start until a real 1->0 edge.
    n_rst = 1'b0;
    serial_in = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(20);
    check("low_rel_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("low_rel_timer", {31'd0, enable_timer}, 32'd0);
    serial_in = 1'b1;
    tick(5);
    rx_frame(8'h96, 1'b1, 1'b0, 1'b0);
    check_rx("rx_96");
    check_flags("b96", 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
